// File: rtl/expr_tx_if.sv
// Parallel-load / serial character-stream bundle for expr_tx.
// master = the serialiser, slave = the loader/consumer side.
interface expr_tx_if #(
  parameter int MAX_TERMS = 8
);
  logic                     start;
  logic [3:0]               num_terms;
  logic [4*MAX_TERMS-1:0]   digits;
  logic [MAX_TERMS-2:0]     ops;
  logic [7:0]               out_char;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    input  start, num_terms, digits, ops, out_ready,
    output out_char, out_valid, busy, done, err
  );

  modport slave (
    output start, num_terms, digits, ops, out_ready,
    input  out_char, out_valid, busy, done, err
  );
endinterface

// File: rtl/expr_tx.sv
// Serialises a captured expression digit (op digit)* as ASCII under valid/ready.
// Optional '=' terminator is enabled by defining EXPR_TX_TERM_EN.
module expr_tx #(
  parameter int MAX_TERMS = 8
) (
  input  logic     clk,
  input  logic     clr,
  expr_tx_if.master bus
);
  localparam int         DW    = 4 * MAX_TERMS;
  localparam int         OW    = MAX_TERMS - 1;
  localparam logic [3:0] MAX_N = 4'(MAX_TERMS);

`ifdef EXPR_TX_TERM_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIG = 2'd1, S_OP = 2'd2, S_TERM = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIG = 2'd1, S_OP = 2'd2} state_t;
`endif

  state_t          state_q;
  logic [3:0]      idx_q;
  logic [3:0]      n_q;
  logic [DW-1:0]   digits_q;
  logic [OW-1:0]   ops_q;
  logic [7:0]      char_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic            start_ok_d;
  logic            xfer_d;
  logic            last_dig_d;
  logic            op_mul_d;
  logic [OW-1:0]   op_sh_d;
  logic [3:0]      next_digit_d;

  function automatic logic [3:0] digit_at(input logic [DW-1:0] d, input logic [3:0] i);
    logic [DW-1:0] sh;
    sh = d >> {i, 2'b00};
    return sh[3:0];
  endfunction

  // A request is legal only with an in-range count and BCD in every used operand.
  always_comb begin
    start_ok_d = (bus.num_terms != 4'd0) && (bus.num_terms <= MAX_N);
    for (int i = 0; i < MAX_TERMS; i++) begin
      start_ok_d = start_ok_d & ~((4'(i) < bus.num_terms) && (bus.digits[4*i +: 4] > 4'd9));
    end
  end

  // Decode helpers for the captured expression at the current index.
  always_comb begin
    xfer_d       = valid_q & bus.out_ready;
    last_dig_d   = (idx_q == (n_q - 4'd1));
    op_sh_d      = ops_q >> idx_q;
    op_mul_d     = op_sh_d[0];
    next_digit_d = digit_at(digits_q, idx_q + 4'd1);
  end

  // Control FSM with registered stream and status outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      n_q      <= 4'd0;
      digits_q <= '0;
      ops_q    <= '0;
      char_q   <= 8'h00;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (start_ok_d) begin
              digits_q <= bus.digits;
              ops_q    <= bus.ops;
              n_q      <= bus.num_terms;
              idx_q    <= 4'd0;
              char_q   <= {4'h3, bus.digits[3:0]};
              valid_q  <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= S_DIG;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DIG: begin
          if (xfer_d) begin
            if (last_dig_d) begin
`ifdef EXPR_TX_TERM_EN
              char_q  <= 8'h3D;
              state_q <= S_TERM;
`else
              char_q  <= 8'h00;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
`endif
            end else begin
              char_q  <= op_mul_d ? 8'h2A : 8'h2B;
              state_q <= S_OP;
            end
          end else begin
            state_q <= S_DIG;
          end
        end
        S_OP: begin
          if (xfer_d) begin
            idx_q   <= idx_q + 4'd1;
            char_q  <= {4'h3, next_digit_d};
            state_q <= S_DIG;
          end else begin
            state_q <= S_OP;
          end
        end
`ifdef EXPR_TX_TERM_EN
        S_TERM: begin
          if (xfer_d) begin
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_TERM;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          char_q  <= 8'h00;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_char  = char_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
